// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_st_e : fetch FSM states (ISSUE / DRAIN / HOLD)
//   INST_W     : instruction width
//   BYTE_W     : memory port data width
package if_fetch_pkg;

  localparam int INST_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,  // requesting bytes k=0..3
    ST_DRAIN = 2'd1,  // last byte granted, waiting for its data
    ST_HOLD  = 2'd2   // instruction presented, waiting for consumption
  } fetch_st_e;

endpackage

// File: rtl/if_inst_buf.sv
// if_inst_buf: {valid, pc, inst} holding register.
//   clk, rst      : clock, synchronous active-high reset
//   ld_i          : capture pc_i/inst_i and set valid
//   clr_i         : drop valid (wins over ld_i)
//   pc_i, inst_i  : entry to capture
//   vld_o, pc_o, inst_o : held entry
module if_inst_buf
  import if_fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              vld_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o
);

  logic              vld_q;
  logic [ADDR_W-1:0] pc_q;
  logic [INST_W-1:0] inst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      pc_q   <= '0;
      inst_q <= '0;
    end else if (clr_i) begin
      vld_q  <= 1'b0;
    end else if (ld_i) begin
      vld_q  <= 1'b1;
      pc_q   <= pc_i;
      inst_q <= inst_i;
    end
  end

  assign vld_o  = vld_q;
  assign pc_o   = pc_q;
  assign inst_o = inst_q;

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage. Owns the fetch PC, reads each 32-bit
// instruction byte-serially (little-endian) from the shared memory port and
// presents {pc, inst} to decode.
//   clk, rst                 : clock, synchronous active-high reset
//   stall_i                  : decode cannot accept; output is held
//   jump_i, jump_addr_i      : redirect (priority over stall/consume)
//   mem_req_o, mem_addr_o    : byte read request, stable until granted
//   mem_gnt_i                : request accepted this cycle
//   mem_data_i               : read byte, valid the cycle after a grant
//   valid_o, pc_o, inst_o    : presented instruction
// Build option IF_SKID_EN: adds a one-entry skid buffer so the next
// instruction is fetched while the output is stalled.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic [BYTE_W-1:0] mem_data_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o
);

  fetch_st_e         state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [1:0]        k_q;      // next byte to request
  logic [1:0]        rk_q;     // byte index of data returning this cycle
  logic              pend_q;   // data returns this cycle
  logic              disc_q;   // returning data belongs to an aborted fetch
  logic [23:0]       asm_q;    // bytes 0..2; byte 3 goes straight to the buffer

  logic              grant, consume, cap, done, issue_ok;
  logic              out_ld, out_clr;
  logic [ADDR_W-1:0] pc_inc, out_ld_pc;
  logic [INST_W-1:0] new_inst, out_ld_inst;

  assign grant    = mem_req_o & mem_gnt_i;
  assign consume  = valid_o & ~stall_i;
  assign cap      = pend_q & ~disc_q & ~jump_i;
  assign done     = cap & (rk_q == 2'd3);
  assign pc_inc   = fetch_pc_q + ADDR_W'(4);
  assign new_inst = {mem_data_i, asm_q};

`ifdef IF_SKID_EN
  logic              skid_vld, skid_ld, skid_clr;
  logic [ADDR_W-1:0] skid_pc;
  logic [INST_W-1:0] skid_inst;

  // Fetch can never complete while the skid entry is full, since issue is
  // blocked until it drains.
  assign issue_ok    = ~skid_vld;
  assign skid_ld     = done & valid_o & ~consume;
  assign skid_clr    = jump_i | (consume & skid_vld);
  assign out_ld      = (done & (~valid_o | consume)) | (consume & skid_vld & ~jump_i);
  assign out_ld_pc   = skid_vld ? skid_pc   : fetch_pc_q;
  assign out_ld_inst = skid_vld ? skid_inst : new_inst;

  if_inst_buf #(.ADDR_W(ADDR_W)) u_skid (
    .clk(clk), .rst(rst), .ld_i(skid_ld), .clr_i(skid_clr),
    .pc_i(fetch_pc_q), .inst_i(new_inst),
    .vld_o(skid_vld), .pc_o(skid_pc), .inst_o(skid_inst)
  );
`else
  assign issue_ok    = 1'b1;
  assign out_ld      = done;
  assign out_ld_pc   = fetch_pc_q;
  assign out_ld_inst = new_inst;
`endif

  assign out_clr = jump_i | (consume & ~out_ld);

  if_inst_buf #(.ADDR_W(ADDR_W)) u_out (
    .clk(clk), .rst(rst), .ld_i(out_ld), .clr_i(out_clr),
    .pc_i(out_ld_pc), .inst_i(out_ld_inst),
    .vld_o(valid_o), .pc_o(pc_o), .inst_o(inst_o)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_ISSUE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (jump_i) begin
      state_d = ST_ISSUE;
    end else begin
      case (state_q)
        ST_ISSUE: if (grant && k_q == 2'd3) state_d = ST_DRAIN;
`ifdef IF_SKID_EN
        ST_DRAIN: if (done) state_d = ST_ISSUE;
`else
        ST_DRAIN: if (done) state_d = ST_HOLD;
`endif
        ST_HOLD:  if (consume) state_d = ST_ISSUE;
        default:  state_d = ST_ISSUE;
      endcase
    end
  end

  // FSM: outputs. In HOLD the byte-0 request of the next instruction goes
  // out in the consuming cycle itself.
  always_comb begin
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    if (!rst) begin
      mem_addr_o = fetch_pc_q + ADDR_W'(k_q);
      case (state_q)
        ST_ISSUE: mem_req_o = issue_ok;
        ST_HOLD: begin
          if (consume && !jump_i) begin
            mem_req_o  = 1'b1;
            mem_addr_o = pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath: PC, byte counters, assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      k_q        <= 2'd0;
      rk_q       <= 2'd0;
      pend_q     <= 1'b0;
      disc_q     <= 1'b0;
      asm_q      <= '0;
    end else begin
      pend_q <= grant;
      rk_q   <= k_q;
      disc_q <= jump_i & grant;
      if (jump_i) begin
        fetch_pc_q <= jump_addr_i;
        k_q        <= 2'd0;
      end else begin
        if (grant) k_q <= k_q + 2'd1;
`ifdef IF_SKID_EN
        if (done) fetch_pc_q <= pc_inc;
`else
        if (state_q == ST_HOLD && consume) fetch_pc_q <= pc_inc;
`endif
      end
      if (cap) begin
        case (rk_q)
          2'd0:    asm_q[7:0]   <= mem_data_i;
          2'd1:    asm_q[15:8]  <= mem_data_i;
          2'd2:    asm_q[23:16] <= mem_data_i;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0, jump_i = 1'b0, mem_gnt_i = 1'b1;
  logic [31:0] jump_addr_i = '0;
  logic        mem_req_o, valid_o;
  logic [31:0] mem_addr_o, pc_o, inst_o;
  logic [7:0]  mem_data_i = 8'h00;

  int checks = 0;
  int errors = 0;

  if_fetch dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .jump_i(jump_i),
    .jump_addr_i(jump_addr_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_data_i(mem_data_i), .valid_o(valid_o),
    .pc_o(pc_o), .inst_o(inst_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0: return 8'h13;  32'h1: return 8'h05;  32'h2: return 8'h10;  32'h3: return 8'h00;
      32'h4: return 8'h93;  32'h5: return 8'h00;  32'h6: return 8'h50;  32'h7: return 8'h00;
      32'h8: return 8'h13;  32'h9: return 8'h01;  32'hA: return 8'hA0;  32'hB: return 8'h00;
      32'h100: return 8'h78; 32'h101: return 8'h56; 32'h102: return 8'h34; 32'h103: return 8'h12;
      32'hFFFFFFFC: return 8'hEF; 32'hFFFFFFFD: return 8'hBE;
      32'hFFFFFFFE: return 8'hAD; 32'hFFFFFFFF: return 8'hDE;
      default: return 8'h00;
    endcase
  endfunction

  // One-cycle-latency memory
  always @(posedge clk) begin
    if (mem_req_o && mem_gnt_i) mem_data_i <= mem_byte(mem_addr_o);
    else                        mem_data_i <= 8'hEE;
  end

  localparam logic [31:0] I0 = 32'h00100513, I1 = 32'h00500093;
  localparam logic [31:0] I2 = 32'h12345678, I3 = 32'h00A00113;

  typedef struct {
    logic        stall, jump;
    logic [31:0] jaddr;
    logic        gnt, ereq;
    logic [31:0] eaddr;
    logic        evld;
    logic [31:0] epc, einst;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic s, input logic j, input logic [31:0] ja, input logic g,
                     input logic er, input logic [31:0] ea,
                     input logic ev, input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.stall = s; v.jump = j; v.jaddr = ja; v.gnt = g; v.ereq = er; v.eaddr = ea;
    v.evld = ev; v.epc = ep; v.einst = ei;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
`ifndef IF_SKID_EN
    // stall jump jaddr gnt | req addr | vld pc inst
    add(0,0,0,1, 1,32'h0, 0,0,0);          // C0: first cycle out of reset
    add(0,0,0,1, 1,32'h1, 0,0,0);
    add(0,0,0,1, 1,32'h2, 0,0,0);
    add(0,0,0,1, 1,32'h3, 0,0,0);
    add(0,0,0,1, 0,32'h0, 0,0,0);          // C4: drain
    add(1,0,0,1, 0,32'h0, 1,32'h0,I0);     // C5-7: stall holds output, no req
    add(1,0,0,1, 0,32'h0, 1,32'h0,I0);
    add(1,0,0,1, 0,32'h0, 1,32'h0,I0);
    add(0,0,0,1, 1,32'h4, 1,32'h0,I0);     // C8: consume, next byte 0 same cycle
    add(0,0,0,1, 1,32'h5, 0,0,0);
    add(0,0,0,0, 1,32'h6, 0,0,0);          // C10-11: grant lost on byte 2
    add(0,0,0,0, 1,32'h6, 0,0,0);
    add(0,0,0,1, 1,32'h6, 0,0,0);
    add(0,0,0,1, 1,32'h7, 0,0,0);
    add(0,0,0,1, 0,32'h0, 0,0,0);
    add(0,0,0,1, 1,32'h8, 1,32'h4,I1);     // C15: 2 cycles late, consume
    add(0,1,32'h100,1, 1,32'h9, 0,0,0);    // C16: jump during byte 1
    add(0,0,0,1, 1,32'h100, 0,0,0);
    add(0,0,0,1, 1,32'h101, 0,0,0);
    add(0,0,0,1, 1,32'h102, 0,0,0);
    add(0,0,0,1, 1,32'h103, 0,0,0);
    add(0,0,0,1, 0,32'h0, 0,0,0);
    add(1,1,32'h8,1, 0,32'h0, 1,32'h100,I2); // C22: jump+stall in HOLD
    add(0,0,0,1, 1,32'h8, 0,0,0);
    add(0,0,0,1, 1,32'h9, 0,0,0);
    add(0,0,0,1, 1,32'hA, 0,0,0);
    add(0,0,0,1, 1,32'hB, 0,0,0);
    add(0,0,0,1, 0,32'h0, 0,0,0);
    add(0,0,0,1, 1,32'hC, 1,32'h8,I3);     // C28
    add(0,0,0,1, 1,32'hD, 0,0,0);
    add(0,0,0,1, 1,32'hE, 0,0,0);
    add(0,1,32'h4,1, 1,32'hF, 0,0,0);      // C31: jump while byte 3 granted
    add(0,0,0,1, 1,32'h4, 0,0,0);
    add(0,0,0,1, 1,32'h5, 0,0,0);          // aborted byte 3 must not complete
    add(0,0,0,1, 1,32'h6, 0,0,0);
    add(0,0,0,1, 1,32'h7, 0,0,0);
    add(0,0,0,1, 0,32'h0, 0,0,0);
    add(0,1,32'hFFFFFFFC,1, 0,32'h0, 1,32'h4,I1); // C37: jump in HOLD, no req
    add(0,0,0,1, 1,32'hFFFFFFFC, 0,0,0);
    add(0,0,0,1, 1,32'hFFFFFFFD, 0,0,0);
    add(0,0,0,1, 1,32'hFFFFFFFE, 0,0,0);
    add(0,0,0,1, 1,32'hFFFFFFFF, 0,0,0);
    add(0,0,0,1, 0,32'h0, 0,0,0);
    add(0,0,0,1, 1,32'h0, 1,32'hFFFFFFFC,32'hDEADBEEF); // C43: PC wraps
    add(0,0,0,1, 1,32'h1, 0,0,0);
    add(0,0,0,1, 1,32'h2, 0,0,0);
`else
    add(0,0,0,1, 1,32'h0, 0,0,0);
    add(0,0,0,1, 1,32'h1, 0,0,0);
    add(0,0,0,1, 1,32'h2, 0,0,0);
    add(0,0,0,1, 1,32'h3, 0,0,0);
    add(0,0,0,1, 0,32'h0, 0,0,0);
    add(1,0,0,1, 1,32'h4, 1,32'h0,I0);     // C5: fetch continues under stall
    add(1,0,0,1, 1,32'h5, 1,32'h0,I0);
    add(1,0,0,1, 1,32'h6, 1,32'h0,I0);
    add(1,0,0,1, 1,32'h7, 1,32'h0,I0);
    add(1,0,0,1, 0,32'h0, 1,32'h0,I0);
    for (int i = 0; i < 5; i++) add(1,0,0,1, 0,32'h0, 1,32'h0,I0); // skid full
    add(0,0,0,1, 0,32'h0, 1,32'h0,I0);     // C15: consume 0x0
    add(1,1,32'h100,1, 1,32'h8, 1,32'h4,I1); // C16: skid moved up; jump flushes
    add(0,0,0,1, 1,32'h100, 0,0,0);
`endif

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst req", mem_req_o, 1'b0);
    chk("rst addr", mem_addr_o, 32'h0);
    chk("rst valid", valid_o, 1'b0);
    chk("rst pc", pc_o, 32'h0);
    chk("rst inst", inst_o, 32'h0);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = 1'b0;
      stall_i = tbl[i].stall; jump_i = tbl[i].jump;
      jump_addr_i = tbl[i].jaddr; mem_gnt_i = tbl[i].gnt;
      #1;
      chk($sformatf("c%0d req", i), mem_req_o, tbl[i].ereq);
      if (tbl[i].ereq) chk($sformatf("c%0d addr", i), mem_addr_o, tbl[i].eaddr);
      chk($sformatf("c%0d valid", i), valid_o, tbl[i].evld);
      if (tbl[i].evld) begin
        chk($sformatf("c%0d pc", i), pc_o, tbl[i].epc);
        chk($sformatf("c%0d inst", i), inst_o, tbl[i].einst);
      end
    end

    // Reset mid-fetch: partial bytes dropped, restart at RESET_PC
    @(negedge clk);
    stall_i = 1'b0; jump_i = 1'b0; mem_gnt_i = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst req", mem_req_o, 1'b0);
    chk("midrst valid", valid_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("restart req", mem_req_o, 1'b1);
    chk("restart addr", mem_addr_o, 32'h0);
    n = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      #1;
      if (valid_o) begin
        n = c;
        break;
      end
    end
    if (n == 0) n = 99;
    chk("restart latency", n, 5);
    chk("restart pc", pc_o, 32'h0);
    chk("restart inst", inst_o, I0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
